// File: rtl/mem_pkg.sv
// Shared constants and types for the memory access stage.
package mem_pkg;

  // Write-back result source select
  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_MEM = 3'd1;
  localparam logic [2:0] RES_PC4 = 3'd2;
  localparam logic [2:0] RES_IMM = 3'd3;
  localparam logic [2:0] RES_PCT = 3'd4;

  // Load func3 encodings (7 is handled as LD)
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  // Store func3 encodings
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for loads and stores plus the size/offset legality check.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] store_data_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o,
  output logic [63:0] load_data_o,
  output logic        misaligned_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [7:0]  be_base;

  assign shamt = {offset_i, 3'b000};

  // Load extraction with sign/zero extension
  always_comb begin
    shifted = rdata_i >> shamt;
    case (func3_i)
      F3_LB:   load_data_o = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  load_data_o = {56'd0, shifted[7:0]};
      F3_LHU:  load_data_o = {48'd0, shifted[15:0]};
      F3_LWU:  load_data_o = {32'd0, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

  // Store lane placement, byte enables and alignment check; size is func3[1:0]
  always_comb begin
    case ({1'b0, func3_i[1:0]})
      F3_SB:   begin be_base = 8'h01; misaligned_o = 1'b0;           end
      F3_SH:   begin be_base = 8'h03; misaligned_o = offset_i[0];    end
      F3_SW:   begin be_base = 8'h0F; misaligned_o = |offset_i[1:0]; end
      default: begin be_base = 8'hFF; misaligned_o = |offset_i;      end
    endcase
    be_o    = be_base << offset_i;
    wdata_o = store_data_i << shamt;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: data-memory request FSM, load/store alignment and MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [2:0]            i_result_src,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [2:0]            i_func3,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [63:0]           o_dmem_wdata,
  output logic [7:0]            o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [63:0]           i_dmem_rdata,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  mem_state_e state_q, state_d;

  logic        is_load, is_store, access, misalign_raw, misaligned, aligned_access;
  logic        complete, load_done;
  logic [63:0] al_wdata, al_load;
  logic [7:0]  al_be;

  logic [2:0]            result_src_q;
  logic                  reg_we_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_target_q;
  logic [DATA_WIDTH-1:0] imm_ext_q, alu_result_q, read_data_q;

  // A store that also selects MEM is treated as a store
  assign is_store       = i_mem_we;
  assign is_load        = (i_result_src == RES_MEM) && !i_mem_we;
  assign access         = is_load || is_store;
  assign misaligned     = access && misalign_raw;
  assign aligned_access = access && !misalign_raw;

  mem_align u_align (
    .func3_i      (i_func3),
    .offset_i     (i_alu_result[2:0]),
    .store_data_i (i_write_data),
    .rdata_i      (i_dmem_rdata),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .load_data_o  (al_load),
    .misaligned_o (misalign_raw)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (aligned_access) begin
          if (!i_dmem_gnt)  state_d = ST_WAIT_GNT;
          else if (is_load) state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_GNT: if (i_dmem_gnt) state_d = is_load ? ST_WAIT_RSP : ST_IDLE;
      ST_WAIT_RSP: if (i_dmem_rvalid) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Request, completion and stall outputs
  always_comb begin
    o_dmem_req = 1'b0;
    complete   = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_dmem_req = aligned_access;
        complete   = aligned_access && is_store && i_dmem_gnt;
      end
      ST_WAIT_GNT: begin
        o_dmem_req = 1'b1;
        complete   = is_store && i_dmem_gnt;
      end
      ST_WAIT_RSP: begin
        complete  = i_dmem_rvalid;
        load_done = i_dmem_rvalid;
      end
      default: ;
    endcase
    o_stall = aligned_access && !complete;
  end

  assign o_dmem_we    = o_dmem_req && is_store;
  assign o_dmem_addr  = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
  assign o_dmem_wdata = (aligned_access && is_store) ? al_wdata : '0;
  assign o_dmem_be    = (aligned_access && is_store) ? al_be : '0;
  assign o_misaligned = misaligned;

  // MEM/WB register: bubble while stalled; misaligned accesses never write rd
  always_ff @(posedge i_clk) begin
    if (!i_rstn || o_stall) begin
      result_src_q <= '0;
      reg_we_q     <= 1'b0;
      rd_addr_q    <= '0;
      pc_plus4_q   <= '0;
      pc_target_q  <= '0;
      imm_ext_q    <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else begin
      result_src_q <= i_result_src;
      reg_we_q     <= i_reg_we && !misaligned;
      rd_addr_q    <= i_rd_addr;
      pc_plus4_q   <= i_pc_plus4;
      pc_target_q  <= i_pc_target;
      imm_ext_q    <= i_imm_ext;
      alu_result_q <= i_alu_result;
      read_data_q  <= load_done ? al_load : '0;
    end
  end

  assign o_result_src = result_src_q;
  assign o_reg_we     = reg_we_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_pc_plus4   = pc_plus4_q;
  assign o_pc_target  = pc_target_q;
  assign o_imm_ext    = imm_ext_q;
  assign o_alu_result = alu_result_q;
  assign o_read_data  = read_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [2:0]  i_result_src;
  logic        i_mem_we, i_reg_we;
  logic [63:0] i_pc_plus4, i_pc_target, i_imm_ext, i_alu_result, i_write_data;
  logic [2:0]  i_func3;
  logic [4:0]  i_rd_addr;
  logic        o_dmem_req, o_dmem_we;
  logic [63:0] o_dmem_addr, o_dmem_wdata;
  logic [7:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [63:0] i_dmem_rdata;
  logic        o_stall, o_misaligned;
  logic [2:0]  o_result_src;
  logic        o_reg_we;
  logic [4:0]  o_rd_addr;
  logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_read_data;

  int n_checks = 0;
  int n_err    = 0;
  int stall_cnt;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .REG_ADDR_W(5)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_result_src(i_result_src), .i_mem_we(i_mem_we), .i_reg_we(i_reg_we),
    .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target), .i_imm_ext(i_imm_ext),
    .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_func3(i_func3),
    .i_rd_addr(i_rd_addr),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_misaligned(o_misaligned),
    .o_result_src(o_result_src), .o_reg_we(o_reg_we), .o_rd_addr(o_rd_addr),
    .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target), .o_imm_ext(o_imm_ext),
    .o_alu_result(o_alu_result), .o_read_data(o_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ins(input logic [2:0] src, input logic we, input logic rwe,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] wd);
    i_result_src = src; i_mem_we = we; i_reg_we = rwe; i_func3 = f3;
    i_rd_addr = rd; i_alu_result = alu; i_write_data = wd;
  endtask

  initial begin
    i_rstn = 1'b0;
    set_ins(3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
    i_pc_plus4 = '0; i_pc_target = '0; i_imm_ext = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    step(); step();

    // Reset state
    chk("rst_reg_we", {63'd0, o_reg_we}, 64'd0);
    chk("rst_rd", {59'd0, o_rd_addr}, 64'd0);
    chk("rst_alu", o_alu_result, 64'd0);
    chk("rst_rdata", o_read_data, 64'd0);
    chk("rst_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_req", {63'd0, o_dmem_req}, 64'd0);
    chk("rst_mis", {63'd0, o_misaligned}, 64'd0);
    chk("rst_be", {56'd0, o_dmem_be}, 64'd0);
    chk("rst_addr", o_dmem_addr, 64'd0);
    chk("rst_wdata", o_dmem_wdata, 64'd0);
    i_rstn = 1'b1;
    step();

    // SD with immediate grant
    set_ins(3'd0, 1'b1, 1'b0, 3'd3, 5'd0, 64'h1000, 64'h1122334455667788);
    i_dmem_gnt = 1'b1;
    #1;
    chk("sd_req", {63'd0, o_dmem_req}, 64'd1);
    chk("sd_we", {63'd0, o_dmem_we}, 64'd1);
    chk("sd_be", {56'd0, o_dmem_be}, 64'hFF);
    chk("sd_addr", o_dmem_addr, 64'h1000);
    chk("sd_wdata", o_dmem_wdata, 64'h1122334455667788);
    chk("sd_stall", {63'd0, o_stall}, 64'd0);
    step();
    chk("sd_wb_alu", o_alu_result, 64'h1000);

    // SB at offset 3
    set_ins(3'd0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h1003, 64'hAB);
    #1;
    chk("sb_be", {56'd0, o_dmem_be}, 64'h08);
    chk("sb_wdata", o_dmem_wdata, 64'h00000000AB000000);
    chk("sb_addr", o_dmem_addr, 64'h1000);
    chk("sb_stall", {63'd0, o_stall}, 64'd0);
    step();
    i_dmem_gnt = 1'b0;

    // LB at 0x2005: grant in third cycle, response three cycles later
    stall_cnt = 0;
    set_ins(3'd1, 1'b0, 1'b1, 3'd0, 5'd5, 64'h2005, 64'd0);
    #1;
    chk("lb_req_c1", {63'd0, o_dmem_req}, 64'd1);
    chk("lb_addr", o_dmem_addr, 64'h2000);
    chk("lb_be", {56'd0, o_dmem_be}, 64'd0);
    chk("lb_we", {63'd0, o_dmem_we}, 64'd0);
    stall_cnt += int'(o_stall);
    step();
    chk("lb_bubble", {63'd0, o_reg_we}, 64'd0);
    chk("lb_req_c2", {63'd0, o_dmem_req}, 64'd1);
    stall_cnt += int'(o_stall);
    step();
    i_dmem_gnt = 1'b1;
    #1;
    chk("lb_req_c3", {63'd0, o_dmem_req}, 64'd1);
    stall_cnt += int'(o_stall);
    step();
    i_dmem_gnt = 1'b0;
    #1;
    chk("lb_req_rsp", {63'd0, o_dmem_req}, 64'd0);
    stall_cnt += int'(o_stall);
    step();
    stall_cnt += int'(o_stall);
    step();
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h112280FF33445566;
    #1;
    chk("lb_stall_rv", {63'd0, o_stall}, 64'd0);
    step();
    i_dmem_rvalid = 1'b0;
    chk("lb_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("lb_data", o_read_data, 64'hFFFFFFFFFFFFFF80);
    chk("lb_reg_we", {63'd0, o_reg_we}, 64'd1);
    chk("lb_rd", {59'd0, o_rd_addr}, 64'd5);
    chk("lb_src", {61'd0, o_result_src}, 64'd1);

    // LBU same byte, minimum latency
    set_ins(3'd1, 1'b0, 1'b1, 3'd4, 5'd6, 64'h2005, 64'd0);
    i_dmem_gnt = 1'b1;
    #1;
    chk("lbu_stall", {63'd0, o_stall}, 64'd1);
    step();
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1;
    step();
    i_dmem_rvalid = 1'b0;
    chk("lbu_data", o_read_data, 64'h80);

    // LH at 0x2004 picks bytes 5:4 = 0x80FF, sign-extended
    set_ins(3'd1, 1'b0, 1'b1, 3'd1, 5'd6, 64'h2004, 64'd0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1;
    step();
    i_dmem_rvalid = 1'b0;
    chk("lh_data", o_read_data, 64'hFFFFFFFFFFFF80FF);

    // Misaligned LW at 0x2006
    set_ins(3'd1, 1'b0, 1'b1, 3'd2, 5'd8, 64'h2006, 64'd0);
    i_dmem_gnt = 1'b1;
    #1;
    chk("mis_flag", {63'd0, o_misaligned}, 64'd1);
    chk("mis_req", {63'd0, o_dmem_req}, 64'd0);
    chk("mis_stall", {63'd0, o_stall}, 64'd0);
    step();
    i_dmem_gnt = 1'b0;
    chk("mis_reg_we", {63'd0, o_reg_we}, 64'd0);
    chk("mis_alu", o_alu_result, 64'h2006);
    set_ins(3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
    #1;
    chk("mis_clear", {63'd0, o_misaligned}, 64'd0);
    step();

    // Reset while waiting for a load response, then a late rvalid
    set_ins(3'd1, 1'b0, 1'b1, 3'd3, 5'd3, 64'h3000, 64'd0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    #1;
    chk("rsp_wait_stall", {63'd0, o_stall}, 64'd1);
    i_rstn = 1'b0;
    set_ins(3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
    step();
    i_rstn = 1'b1;
    chk("abort_reg_we", {63'd0, o_reg_we}, 64'd0);
    chk("abort_stall", {63'd0, o_stall}, 64'd0);
    set_ins(3'd1, 1'b0, 1'b1, 3'd3, 5'd4, 64'h3008, 64'd0);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hDEADBEEFDEADBEEF;
    #1;
    chk("late_req", {63'd0, o_dmem_req}, 64'd1);
    chk("late_stall", {63'd0, o_stall}, 64'd1);
    step();
    i_dmem_rvalid = 1'b0;
    chk("late_reg_we", {63'd0, o_reg_we}, 64'd0);
    chk("late_rdata", o_read_data, 64'd0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h0123456789ABCDEF;
    step();
    i_dmem_rvalid = 1'b0;
    chk("ld2_data", o_read_data, 64'h0123456789ABCDEF);
    chk("ld2_rd", {59'd0, o_rd_addr}, 64'd4);

    // ADD followed by back-to-back LD
    set_ins(3'd0, 1'b0, 1'b1, 3'd0, 5'd7, 64'h42, 64'd0);
    i_pc_plus4 = 64'h104; i_pc_target = 64'h200; i_imm_ext = 64'h33;
    #1;
    chk("add_stall", {63'd0, o_stall}, 64'd0);
    chk("add_req", {63'd0, o_dmem_req}, 64'd0);
    step();
    chk("add_reg_we", {63'd0, o_reg_we}, 64'd1);
    chk("add_rd", {59'd0, o_rd_addr}, 64'd7);
    chk("add_alu", o_alu_result, 64'h42);
    chk("add_src", {61'd0, o_result_src}, 64'd0);
    chk("add_pc4", o_pc_plus4, 64'h104);
    chk("add_pct", o_pc_target, 64'h200);
    chk("add_imm", o_imm_ext, 64'h33);
    set_ins(3'd1, 1'b0, 1'b1, 3'd3, 5'd9, 64'h4000, 64'd0);
    i_dmem_gnt = 1'b1;
    #1;
    chk("ld3_stall", {63'd0, o_stall}, 64'd1);
    step();
    chk("ld3_bubble_we", {63'd0, o_reg_we}, 64'd0);
    chk("ld3_bubble_rd", {59'd0, o_rd_addr}, 64'd0);
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hCAFEBABE12345678;
    #1;
    chk("ld3_stall_rv", {63'd0, o_stall}, 64'd0);
    step();
    i_dmem_rvalid = 1'b0;
    chk("ld3_data", o_read_data, 64'hCAFEBABE12345678);
    chk("ld3_rd", {59'd0, o_rd_addr}, 64'd9);
    chk("ld3_reg_we", {63'd0, o_reg_we}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
